// File: rtl/unidade_controle_quiz.sv
// Quiz game control unit: steps through N_RODADAS questions, captures the
// player's button press, compares it with the answer from question memory
// and keeps the score. Define QUIZ_TIMEOUT_EN to enable the per-answer
// timeout (timer and ESGOTADO state); without it ESPERA waits indefinitely
// and esgotou stays low.
module unidade_controle_quiz #(
    parameter int N_RODADAS      = 16,
    parameter int N_OPCOES       = 4,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int RW = $clog2(N_RODADAS),
    localparam int OW = $clog2(N_OPCOES),
    localparam int PW = $clog2(N_RODADAS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          iniciar,
    input  logic          jogada_feita,
    input  logic [OW-1:0] opcao,
    input  logic [OW-1:0] resposta_mem,
    output logic [RW-1:0] endereco,
    output logic          registraM,
    output logic [PW-1:0] pontos,
    output logic          acertou,
    output logic          errou,
    output logic          esgotou,
    output logic          pronto,
    output logic [3:0]    db_estado
);

    typedef enum logic [3:0] {
        StInicial  = 4'd0,
        StPrepara  = 4'd1,
        StCarrega  = 4'd3,
        StEspera   = 4'd7,
        StCompara  = 4'd8,
        StRegistra = 4'd9,
        StAcerto   = 4'd10,
        StErro     = 4'd11,
        StEsgotado = 4'd12,
        StAvanca   = 4'd13,
        StFim      = 4'd15
    } estado_e;

    estado_e       estado_q, estado_d;
    logic [RW-1:0] endereco_q, endereco_d;
    logic [PW-1:0] pontos_q, pontos_d;
    logic [OW-1:0] captura_q, captura_d;

`ifdef QUIZ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    logic [TW-1:0] timer_q, timer_d;

    // Answer timer register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= StInicial;
            endereco_q <= '0;
            pontos_q   <= '0;
            captura_q  <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            pontos_q   <= pontos_d;
            captura_q  <= captura_d;
        end
    end

    // Next-state, datapath updates and Moore outputs
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        pontos_d   = pontos_q;
        captura_d  = captura_q;
`ifdef QUIZ_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        registraM  = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        esgotou    = 1'b0;
        pronto     = 1'b0;

        case (estado_q)
            StInicial: begin
                endereco_d = '0;
                pontos_d   = '0;
                captura_d  = '0;
`ifdef QUIZ_TIMEOUT_EN
                timer_d    = '0;
`endif
                if (iniciar) begin
                    estado_d = StPrepara;
                end
            end
            StPrepara: begin
                endereco_d = '0;
                pontos_d   = '0;
                captura_d  = '0;
`ifdef QUIZ_TIMEOUT_EN
                timer_d    = '0;
`endif
                estado_d   = StCarrega;
            end
            StCarrega: begin
                registraM = 1'b1;
`ifdef QUIZ_TIMEOUT_EN
                timer_d   = '0;
`endif
                estado_d  = StEspera;
            end
            StEspera: begin
`ifdef QUIZ_TIMEOUT_EN
                timer_d = timer_q + TW'(1);
                // A press on the last allowed cycle still counts as an answer
                if (jogada_feita) begin
                    estado_d = StRegistra;
                end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    estado_d = StEsgotado;
                end
`else
                if (jogada_feita) begin
                    estado_d = StRegistra;
                end
`endif
            end
            StRegistra: begin
                captura_d = opcao;
                estado_d  = StCompara;
            end
            StCompara: begin
                // Out-of-range button codes are never correct
                if ((captura_q == resposta_mem) && (int'(captura_q) < N_OPCOES)) begin
                    estado_d = StAcerto;
                end else begin
                    estado_d = StErro;
                end
            end
            StAcerto: begin
                acertou = 1'b1;
                if (pontos_q < PW'(N_RODADAS)) begin
                    pontos_d = pontos_q + PW'(1);
                end
                estado_d = StAvanca;
            end
            StErro: begin
                errou    = 1'b1;
                estado_d = StAvanca;
            end
            StEsgotado: begin
`ifdef QUIZ_TIMEOUT_EN
                esgotou  = 1'b1;
`endif
                estado_d = StAvanca;
            end
            StAvanca: begin
                if (endereco_q == RW'(N_RODADAS - 1)) begin
                    estado_d = StFim;
                end else begin
                    endereco_d = endereco_q + RW'(1);
                    estado_d   = StCarrega;
                end
            end
            StFim: begin
                pronto = 1'b1;
                // Restart clears score at once so PREPARA already shows zero
                if (iniciar) begin
                    endereco_d = '0;
                    pontos_d   = '0;
                    captura_d  = '0;
`ifdef QUIZ_TIMEOUT_EN
                    timer_d    = '0;
`endif
                    estado_d   = StPrepara;
                end
            end
            default: begin
                endereco_d = '0;
                pontos_d   = '0;
                captura_d  = '0;
`ifdef QUIZ_TIMEOUT_EN
                timer_d    = '0;
`endif
                estado_d   = StInicial;
            end
        endcase
    end

    assign endereco  = endereco_q;
    assign pontos    = pontos_q;
    assign db_estado = estado_q;

endmodule

// File: doc/unidade_controle_quiz.md
UNIDADE_CONTROLE_QUIZ -- requirements
Module: unidade_controle_quiz

Interface
REQ-001 The block SHALL have parameter N_RODADAS, default 16, meaning questions per game (minimum 2).
REQ-002 The block SHALL have parameter N_OPCOES, default 4, meaning answer buttons per question (minimum 2).
REQ-003 The block SHALL have parameter TIMEOUT_CICLOS, default 5000, meaning clock cycles allowed per answer (minimum 2).
REQ-004 The block SHALL derive widths RW=clog2(N_RODADAS), OW=clog2(N_OPCOES), PW=clog2(N_RODADAS+1), and timer width TW=clog2(TIMEOUT_CICLOS).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-006 clock  in  1  system clock, all state on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 iniciar  in  1  start/restart game request.
REQ-009 jogada_feita  in  1  answer button event, sampled in ESPERA only.
REQ-010 opcao  in  OW  index of pressed button.
REQ-011 resposta_mem  in  OW  correct answer read from question memory at endereco.
REQ-012 endereco  out  RW  current question index.
REQ-013 registraM  out  1  one-cycle load strobe for question memory register.
REQ-014 pontos  out  PW  correct-answer count.
REQ-015 acertou / errou / esgotou  out  1 each  one-cycle result pulses.
REQ-016 pronto  out  1  game finished, level.
REQ-017 db_estado  out  4  current state code.

Function
REQ-018 The FSM SHALL use codes INICIAL=0, PREPARA=1, CARREGA=3, ESPERA=7, COMPARA=8, REGISTRA=9, ACERTO=10, ERRO=11, ESGOTADO=12, AVANCA=13, FIM=15; db_estado SHALL equal the current code.
REQ-019 INICIAL: all outputs low; iniciar=1 -> PREPARA, else stay.
REQ-020 PREPARA: clear endereco, pontos, timer and captured answer -> CARREGA.
REQ-021 CARREGA: registraM=1 for this cycle, timer cleared -> ESPERA.
REQ-022 ESPERA: timer increments once per cycle; jogada_feita=1 -> REGISTRA; else timer==TIMEOUT_CICLOS-1 -> ESGOTADO; else stay.
REQ-023 jogada_feita and timeout in the same cycle SHALL resolve to REGISTRA.
REQ-024 REGISTRA: capture opcao into an internal OW-bit register -> COMPARA.
REQ-025 COMPARA: captured==resposta_mem and captured<N_OPCOES -> ACERTO, else ERRO.
REQ-026 ACERTO: acertou=1, pontos+1 -> AVANCA; ERRO: errou=1 -> AVANCA; ESGOTADO: esgotou=1 -> AVANCA.
REQ-027 AVANCA: endereco==N_RODADAS-1 -> FIM; else endereco+1 -> CARREGA.
REQ-028 FIM: pronto=1, pontos and endereco held; iniciar=1 -> PREPARA (direct restart), else stay.
REQ-029 acertou SHALL be high in the third cycle after the edge that samples jogada_feita=1 in ESPERA.
REQ-030 pontos SHALL never exceed N_RODADAS; no wrap-around is possible.
REQ-031 Unused state codes SHALL transition to INICIAL on the next edge.
REQ-032 registraM, acertou, errou, esgotou SHALL be low in every state not listed as asserting them.

Reset
REQ-033 reset_n=0 SHALL immediately force INICIAL, endereco=0, pontos=0, timer=0, captured answer=0, all outputs low, regardless of current state.
REQ-034 Release of reset_n SHALL be followed by normal operation from INICIAL on the next rising edge.

Configuration
REQ-035 Macro QUIZ_TIMEOUT_EN defined: timer and ESGOTADO behave per REQ-022/023/026.
REQ-036 QUIZ_TIMEOUT_EN undefined: no timer logic, ESPERA waits indefinitely, esgotou tied low, ESGOTADO unreachable.

Verification (N_RODADAS=4, N_OPCOES=4, TIMEOUT_CICLOS=8)
REQ-037 Four correct answers (opcao==resposta_mem) -> four acertou pulses, pontos=4, pronto=1, db_estado=15.
REQ-038 Answers correct, wrong, correct, wrong -> pontos=2, two errou pulses, pronto=1.
REQ-039 No jogada in question 0 with QUIZ_TIMEOUT_EN -> esgotou pulse 8 cycles after entering ESPERA, endereco becomes 1, pontos=0.
REQ-040 jogada_feita asserted exactly on the timeout cycle -> REGISTRA taken, no esgotou pulse.
REQ-041 reset_n=0 while in ESPERA of question 2 with pontos=2 -> db_estado=0, pontos=0, endereco=0 without a clock edge.
REQ-042 iniciar=1 in FIM with pontos=3 -> PREPARA, pontos=0, registraM pulse two cycles later with endereco=0.
